class_argmax: RTL and testbench

- Sits directly downstream of the CNN word-stream adapter.
- Consumes the serialized class scores, one 32-bit word per class, NUM_CLASSES words per frame.
- Tracks the running maximum and emits a single 32-bit result word per frame: winning class index, winning score and frame sequence number.
- Uses the same valid/stall word handshake as the adapter, so it can be chained or fed straight to the host FIFO.

---
 rtl/cnn_stream_pkg.sv | 29 ++
 rtl/class_argmax.sv | 109 ++++++++++
 tb/tb_class_argmax.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cnn_stream_pkg.sv
// Shared definitions for the CNN word stream: result-word field positions,
// the argmax state encoding and the score comparator.
package cnn_stream_pkg;

    localparam int IDX_LSB        = 0;
    localparam int VAL_LSB        = 8;
    localparam int SEQ_LSB        = 16;
    localparam int LAST_BIT       = 30;
    localparam int HARD_RESET_BIT = 31;

    localparam int IDX_FIELD_W = 8;
    localparam int VAL_FIELD_W = 8;
    localparam int SEQ_FIELD_W = 14;

    typedef enum logic {
        ACCUM = 1'b0,
        EMIT  = 1'b1
    } argmax_state_t;

    // Both operands arrive already widened to 8 bits by the caller.
    function automatic logic score_gt(input logic [7:0] a, input logic [7:0] b,
                                      input logic is_signed);
        if (is_signed) begin
            return $signed(a) > $signed(b);
        end
        return a > b;
    endfunction

endpackage

// File: rtl/class_argmax.sv
// Running argmax over NUM_CLASSES score words per frame; emits one result word
// (class index, score, frame sequence number) per frame on the word stream.
//
// state | meaning
// ACCUM | accepting score words, tracking best score and its index
// EMIT  | result word presented; held while the consumer stalls
module class_argmax
    import cnn_stream_pkg::*;
#(
    parameter int NUM_CLASSES   = 10,
    parameter int VALUE_BITS    = 8,
    parameter int SIGNED_SCORES = 1,
    parameter int WORD_SIZE     = 32,
    parameter int SEQ_BITS      = 14
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [WORD_SIZE-1:0] in_data,
    input  logic                 in_valid,
    output logic                 upstream_stall,
    output logic [WORD_SIZE-1:0] out_data,
    output logic                 out_valid,
    input  logic                 downstream_stall
);

    localparam int IDX_W = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;
    localparam logic [IDX_W-1:0] LAST_CNT = IDX_W'(NUM_CLASSES - 1);

    argmax_state_t state, state_nxt;
    logic [IDX_W-1:0]      cnt, cnt_nxt;
    logic [IDX_W-1:0]      best_idx, best_idx_nxt;
    logic [VALUE_BITS-1:0] best_val, best_val_nxt;
    logic [SEQ_BITS-1:0]   seq, seq_nxt;
    logic [VALUE_BITS-1:0] score;
    logic                  in_xfer;
    logic                  out_xfer;
    logic                  unused_in_bits;

    assign score          = in_data[VALUE_BITS-1:0];
    assign unused_in_bits = ^in_data[WORD_SIZE-1:VALUE_BITS];

    // Scores are widened to the 8-bit result field the same way they are compared.
    function automatic logic [7:0] widen(input logic [VALUE_BITS-1:0] v);
        if (SIGNED_SCORES != 0) begin
            return 8'($signed(v));
        end
        return 8'(v);
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= ACCUM;
            cnt      <= '0;
            best_idx <= '0;
            best_val <= '0;
            seq      <= '0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            best_idx <= best_idx_nxt;
            best_val <= best_val_nxt;
            seq      <= seq_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        best_idx_nxt   = best_idx;
        best_val_nxt   = best_val;
        seq_nxt        = seq;
        upstream_stall = 1'b0;
        out_valid      = 1'b0;
        out_data       = '0;

        if (state == EMIT) begin
            out_valid      = 1'b1;
            upstream_stall = downstream_stall;
            out_data[IDX_LSB +: IDX_FIELD_W] = IDX_FIELD_W'(best_idx);
            out_data[VAL_LSB +: VAL_FIELD_W] = widen(best_val);
            out_data[SEQ_LSB +: SEQ_FIELD_W] = SEQ_FIELD_W'(seq);
            out_data[LAST_BIT]               = 1'b1;
            out_data[HARD_RESET_BIT]         = 1'b0;
        end

        in_xfer  = in_valid && !upstream_stall;
        out_xfer = out_valid && !downstream_stall;

        if (out_xfer) begin
            seq_nxt   = seq + 1'b1;
            state_nxt = ACCUM;
        end

        // cnt is already 0 in EMIT, so a word taken alongside the result starts the next frame.
        if (in_xfer) begin
            if ((cnt == '0) || score_gt(widen(score), widen(best_val), SIGNED_SCORES != 0)) begin
                best_val_nxt = score;
                best_idx_nxt = cnt;
            end
            if (cnt == LAST_CNT) begin
                cnt_nxt   = '0;
                state_nxt = EMIT;
            end else begin
                cnt_nxt = cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_class_argmax.sv
// Scoreboard bench for class_argmax: signed and unsigned instances share one
// directed stream; a 2-class instance runs the sequence-number wrap.
module tb_class_argmax;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] in_data;
    logic        in_valid;
    logic        downstream_stall;
    logic        stall_s, stall_u, out_valid_s, out_valid_u;
    logic [31:0] out_data_s, out_data_u;

    logic        w_reset;
    logic [31:0] w_in_data;
    logic        w_in_valid;
    logic        w_stall_out, w_out_valid;
    logic [31:0] w_out_data;
    logic        w_ds_stall;
    logic        w_done;

    int errors = 0;
    int checks = 0;
    int w_count = 0;

    logic [31:0] exp_s[$];
    logic [31:0] exp_u[$];
    logic [31:0] exp_w[$];
    logic [13:0] seq_exp;

    localparam int W_FRAMES = 16386;

    logic [7:0] frames [5][10];
    logic [7:0] idx_u [5];
    logic [7:0] val_u [5];
    logic [7:0] idx_s [5];
    logic [7:0] val_s [5];

    always #5 clock = ~clock;

    class_argmax #(.SIGNED_SCORES(1)) dut_s (
        .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .upstream_stall(stall_s), .out_data(out_data_s), .out_valid(out_valid_s),
        .downstream_stall(downstream_stall)
    );

    class_argmax #(.SIGNED_SCORES(0)) dut_u (
        .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .upstream_stall(stall_u), .out_data(out_data_u), .out_valid(out_valid_u),
        .downstream_stall(downstream_stall)
    );

    class_argmax #(.NUM_CLASSES(2), .SIGNED_SCORES(1), .SEQ_BITS(14)) dut_w (
        .clock(clock), .reset(w_reset), .in_data(w_in_data), .in_valid(w_in_valid),
        .upstream_stall(w_stall_out), .out_data(w_out_data), .out_valid(w_out_valid),
        .downstream_stall(w_ds_stall)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] mk(input logic [7:0] idx, input logic [7:0] val,
                                       input logic [13:0] seq);
        return {2'b01, seq, val, idx};
    endfunction

    // Monitors: pop an expectation whenever a result transfers.
    always @(negedge clock) begin
        if (!reset) begin
            if (out_valid_s && !downstream_stall) begin
                if (exp_s.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_s: got %h required no output", out_data_s);
                end else begin
                    check("result_s", out_data_s, exp_s.pop_front());
                end
            end
            if (out_valid_u && !downstream_stall) begin
                if (exp_u.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_u: got %h required no output", out_data_u);
                end else begin
                    check("result_u", out_data_u, exp_u.pop_front());
                end
            end
            if (!out_valid_s) check("idle_zero_s", out_data_s, 32'h0);
            if (!out_valid_u) check("idle_zero_u", out_data_u, 32'h0);
        end
    end

    always @(negedge clock) begin
        if (!w_reset && w_out_valid) begin
            w_count++;
            if (exp_w.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_w: got %h required no output", w_out_data);
            end else begin
                check("wrap_result", w_out_data, exp_w.pop_front());
            end
        end
    end

    task automatic push_frame(input int f);
        exp_s.push_back(mk(idx_s[f], val_s[f], seq_exp));
        exp_u.push_back(mk(idx_u[f], val_u[f], seq_exp));
        seq_exp = seq_exp + 14'd1;
    endtask

    task automatic send_word(input logic [7:0] v, input int gap);
        logic [31:0] r;
        int n;
        for (int k = 0; k < gap; k++) begin
            @(posedge clock); #1;
            in_valid = 1'b0;
            @(negedge clock);
            check("no_early_valid", {31'h0, out_valid_s | out_valid_u}, 32'h0);
        end
        @(posedge clock); #1;
        r = $urandom();
        in_valid = 1'b1;
        in_data  = {r[31:8], v};
        @(negedge clock);
        n = 0;
        while ((stall_s || stall_u) && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (n >= 50) begin
            checks++; errors++;
            $display("FAIL input_timeout: stall still 1 required 0");
        end
    endtask

    task automatic send_frame(input int f, input int words, input logic gaps);
        for (int w = 0; w < words; w++) begin
            send_word(frames[f][w], gaps ? int'($urandom_range(0, 2)) : 0);
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clock); #1;
            in_valid = 1'b0;
        end
    endtask

    // Sequence-wrap driver: 2-class frames, one word per cycle, never stalled.
    initial begin
        logic [31:0] r;
        w_done     = 1'b0;
        w_reset    = 1'b1;
        w_in_valid = 1'b0;
        w_in_data  = '0;
        w_ds_stall = 1'b0;
        repeat (3) @(posedge clock);
        #1 w_reset = 1'b0;
        for (int f = 0; f < W_FRAMES; f++) begin
            exp_w.push_back(mk(8'd1, 8'd2, 14'(f)));
            for (int w = 0; w < 2; w++) begin
                @(posedge clock); #1;
                r = $urandom();
                w_in_valid = 1'b1;
                w_in_data  = {r[31:8], 8'(w + 1)};
            end
        end
        @(posedge clock); #1;
        w_in_valid = 1'b0;
        repeat (5) @(posedge clock);
        w_done = 1'b1;
    end

    initial begin
        logic [31:0] hold_s, hold_u;
        int n;
        frames = '{
            '{8'd3, 8'd9, 8'd200, 8'd7, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0},
            '{8'h80, 8'hF0, 8'h05, 8'h05, 8'h7F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
            '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF},
            '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h10},
            '{8'h10, 8'h20, 8'h30, 8'h05, 8'hFE, 8'h40, 8'h40, 8'h3F, 8'h00, 8'h81}
        };
        idx_u = '{8'd2, 8'd1, 8'd0, 8'd9, 8'd4};
        val_u = '{8'hC8, 8'hF0, 8'hFF, 8'h10, 8'hFE};
        idx_s = '{8'd1, 8'd4, 8'd0, 8'd9, 8'd5};
        val_s = '{8'h09, 8'h7F, 8'hFF, 8'h10, 8'h40};
        seq_exp          = '0;
        reset            = 1'b1;
        in_valid         = 1'b0;
        in_data          = '0;
        downstream_stall = 1'b1;

        repeat (3) @(posedge clock);
        @(negedge clock);
        check("reset_valid", {31'h0, out_valid_s | out_valid_u}, 32'h0);
        check("reset_data_s", out_data_s, 32'h0);
        check("reset_stall", {31'h0, stall_s | stall_u}, 32'h0);
        @(posedge clock); #1;
        reset = 1'b0;
        downstream_stall = 1'b0;

        // Frame 0: unsigned result 0x4000C802; result one cycle after the last word.
        push_frame(0);
        send_frame(0, 10, 1'b0);
        idle(1);
        @(negedge clock);
        check("latency_valid_s", {31'h0, out_valid_s}, 32'h1);
        check("latency_data_u", out_data_u, 32'h4000C802);

        // Frames 1 and 2 back-to-back.
        push_frame(1);
        send_frame(1, 10, 1'b0);
        push_frame(2);
        send_frame(2, 10, 1'b0);
        idle(3);

        // Output stall held in EMIT while word 0 of the next frame waits.
        downstream_stall = 1'b1;
        push_frame(3);
        send_frame(3, 10, 1'b0);
        push_frame(4);
        @(posedge clock); #1;
        in_valid = 1'b1;
        in_data  = {24'h5A5A5A, frames[4][0]};
        @(negedge clock);
        hold_s = out_data_s;
        hold_u = out_data_u;
        check("stall_valid", {31'h0, out_valid_s & out_valid_u}, 32'h1);
        check("stall_data_s", hold_s, mk(8'd9, 8'h10, 14'd3));
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            check("stall_up", {31'h0, stall_s & stall_u}, 32'h1);
            check("stall_hold_s", out_data_s, hold_s);
            check("stall_hold_u", out_data_u, hold_u);
        end
        @(posedge clock); #1;
        downstream_stall = 1'b0;
        for (int w = 1; w < 10; w++) send_word(frames[4][w], 0);
        idle(3);

        // Gaps inside a frame give the gap-free result.
        push_frame(1);
        send_frame(1, 10, 1'b1);
        idle(4);

        // Reset after 6 words discards the partial frame and the sequence count.
        send_frame(4, 6, 1'b0);
        @(posedge clock); #1;
        in_valid = 1'b0;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        seq_exp = '0;
        push_frame(0);
        send_frame(0, 10, 1'b0);
        idle(4);

        // Reset during EMIT drops the pending result.
        downstream_stall = 1'b1;
        send_frame(2, 10, 1'b0);
        idle(1);
        @(negedge clock);
        check("emit_before_reset", {31'h0, out_valid_s}, 32'h1);
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        downstream_stall = 1'b0;
        @(negedge clock);
        check("valid_after_reset", {31'h0, out_valid_s | out_valid_u}, 32'h0);
        check("data_after_reset", out_data_s, 32'h0);
        seq_exp = '0;
        push_frame(3);
        send_frame(3, 10, 1'b0);
        idle(4);

        n = 0;
        while (!w_done && n < 60000) begin
            @(posedge clock);
            n++;
        end
        if (!w_done) begin
            checks++; errors++;
            $display("FAIL wrap_timeout: done 0 required 1");
        end
        repeat (3) @(negedge clock);
        check("queue_s_empty", 32'(exp_s.size()), 32'h0);
        check("queue_u_empty", 32'(exp_u.size()), 32'h0);
        check("queue_w_empty", 32'(exp_w.size()), 32'h0);
        check("wrap_count", 32'(w_count), 32'(W_FRAMES));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
